// File: rtl/ex_rt_merge_buffer_pkg.sv
// ex_rt_merge_buffer_pkg: shared entry type and widths for the execute->retire merge buffer.
// Contents: res_st_cell_t result-state tag, ex_rt_entry_t {comp_result, value, op},
// EX_RT_ENTRY_W entry width, MAX_EX_LANES lane ceiling, lane_w() lane-index width helper.
package ex_rt_merge_buffer_pkg;
    typedef enum logic [1:0] {RES_NONE, RES_ALU, RES_LD, RES_ST} res_st_cell_t;
    typedef struct packed {
        logic         comp_result;
        logic [31:0]  value;
        res_st_cell_t op;
    } ex_rt_entry_t;
    localparam int EX_RT_ENTRY_W = $bits(res_st_cell_t) + 33;
    localparam int MAX_EX_LANES  = 8;
    function automatic int lane_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/ex_rt_merge_buffer_lane_fifo.sv
// ex_rt_merge_buffer_lane_fifo: one in-order lane FIFO of the execute->retire merge buffer.
// Ports: clk, rst (async, active-low), flush (sync, empties the lane), push/din (write),
// pop (drop head), dout (head entry), count (occupancy), full, empty.
// Caller guarantees push only when !full and pop only when !empty.
module ex_rt_merge_buffer_lane_fifo #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 35,
    localparam int PTR_W     = $clog2(DEPTH),
    localparam int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [CNT_W-1:0]      count,
    output logic                  full,
    output logic                  empty
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    always_comb begin
        rd_d  = flush ? '0 : rd_q + PTR_W'(pop);
        wr_d  = flush ? '0 : wr_q + PTR_W'(push);
        cnt_d = flush ? '0 : cnt_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage is deliberately not reset or flushed; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_q] <= din;
    end

    assign dout  = mem_q[rd_q];
    assign count = cnt_q;
    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign empty = (cnt_q == '0);
endmodule

// File: rtl/ex_rt_merge_buffer.sv
// ex_rt_merge_buffer: NUM_LANES in-order lane FIFOs merged round-robin into one retire stream.
// Ports: clk, rst (async, active-low), flush (sync mispredict flush),
// in_valid/in_ready/in_data (per-lane push), out_valid/out_ready/out_data/out_lane (merged pop),
// lane_count (per-lane occupancy), any_full (OR of lane full flags).
// Macro QU_MERGE_BYPASS_EN: when every lane is empty, present the incoming entry in the same
// cycle and skip the lane write if retire accepts it.
module ex_rt_merge_buffer
    import ex_rt_merge_buffer_pkg::*;
#(
    parameter int NUM_LANES  = 2,
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = EX_RT_ENTRY_W,
    localparam int LANE_W    = lane_w(NUM_LANES),
    localparam int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic [NUM_LANES-1:0]            in_valid,
    output logic [NUM_LANES-1:0]            in_ready,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic [LANE_W-1:0]               out_lane,
    output logic [NUM_LANES*CNT_W-1:0]      lane_count,
    output logic                            any_full
);
    logic                  ready_en_q, ready_en_d;
    logic                  lock_q, lock_d;
    logic [LANE_W-1:0]     rr_ptr_q, rr_ptr_d, lock_lane_q, lock_lane_d, grant;
    logic                  pop, byp;
    int                    nxt;
    logic [NUM_LANES-1:0]  full, empty, push_req, lane_push, lane_pop;
    logic [DATA_WIDTH-1:0] lane_din  [NUM_LANES];
    logic [DATA_WIDTH-1:0] lane_dout [NUM_LANES];
    logic [CNT_W-1:0]      lane_cnt  [NUM_LANES];

    // First requesting lane at or after ptr, wrapping; scanning far-to-near lets the nearest win.
    function automatic logic [LANE_W-1:0] rr_pick(input logic [NUM_LANES-1:0] req,
                                                  input logic [LANE_W-1:0]    ptr);
        logic [LANE_W-1:0] r = ptr;
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            int j = int'(ptr) + k;
            if (j >= NUM_LANES) j -= NUM_LANES;
            if (|(req & (NUM_LANES'(1) << j))) r = LANE_W'(j);
        end
        return r;
    endfunction

    assign in_ready = {NUM_LANES{ready_en_q & !flush}} & ~full;
    assign push_req = in_valid & in_ready;

`ifdef QU_MERGE_BYPASS_EN
    assign byp = (&empty) & !lock_q & (|push_req);
`else
    assign byp = 1'b0;
`endif

    // A held grant stays on its lane until popped so retire never sees out_data change under stall.
    assign grant     = lock_q ? lock_lane_q : rr_pick(byp ? push_req : ~empty, rr_ptr_q);
    assign out_valid = (!(&empty) | byp) & !flush;
    assign pop       = out_valid & out_ready;
    assign out_data  = out_valid ? (byp ? lane_din[grant] : lane_dout[grant]) : '0;
    assign out_lane  = out_valid ? grant : '0;
    assign any_full  = |full;

    always_comb begin
        nxt         = int'(grant) + 1;
        ready_en_d  = 1'b1;
        lock_d      = !flush & out_valid & !out_ready;
        lock_lane_d = grant;
        rr_ptr_d    = flush ? '0 : (pop ? ((nxt >= NUM_LANES) ? '0 : LANE_W'(nxt)) : rr_ptr_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_en_q  <= 1'b0;
            lock_q      <= 1'b0;
            lock_lane_q <= '0;
            rr_ptr_q    <= '0;
        end else begin
            ready_en_q  <= ready_en_d;
            lock_q      <= lock_d;
            lock_lane_q <= lock_lane_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign lane_din[i]                  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
        assign lane_count[i*CNT_W +: CNT_W] = lane_cnt[i];
        // A bypassed entry consumed by retire this cycle never enters its lane.
        assign lane_push[i] = push_req[i] & !(byp & out_ready & (grant == LANE_W'(i)));
        assign lane_pop[i]  = pop & !byp & (grant == LANE_W'(i));
        ex_rt_merge_buffer_lane_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .flush (flush),
            .push  (lane_push[i]),
            .pop   (lane_pop[i]),
            .din   (lane_din[i]),
            .dout  (lane_dout[i]),
            .count (lane_cnt[i]),
            .full  (full[i]),
            .empty (empty[i])
        );
    end
endmodule

// File: tb/tb_ex_rt_merge_buffer.sv
// tb_ex_rt_merge_buffer: directed table-driven bench for ex_rt_merge_buffer (2 lanes, depth 4).
module tb_ex_rt_merge_buffer;
    localparam int NL = 2;
    localparam int DW = 35;
    localparam int CW = 3;
`ifdef QU_MERGE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk = 1'b0, rst = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [NL-1:0]    in_valid = '0, in_ready;
    logic [NL*DW-1:0] in_data = '0;
    logic             out_valid, any_full;
    logic [DW-1:0]    out_data;
    logic             out_lane;
    logic [NL*CW-1:0] lane_count;
    int               n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    ex_rt_merge_buffer dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_lane(out_lane),
        .lane_count(lane_count), .any_full(any_full)
    );

    typedef struct {
        logic          fl;
        logic [1:0]    iv;
        logic [DW-1:0] d0, d1;
        logic          ordy;
        logic          ev;
        logic [DW-1:0] ed;
        logic          el;
        logic [2:0]    c0, c1;
        logic [1:0]    er;
        logic          ef;
    } vec_t;

    vec_t v[$];

    function automatic vec_t mk(input logic fl, input logic [1:0] iv, input logic [DW-1:0] d0, d1,
                                input logic ordy, input logic ev, input logic [DW-1:0] ed,
                                input logic el, input logic [2:0] c0, c1, input logic [1:0] er,
                                input logic ef);
        vec_t r;
        r.fl = fl; r.iv = iv; r.d0 = d0; r.d1 = d1; r.ordy = ordy;
        r.ev = ev; r.ed = ed; r.el = el; r.c0 = c0; r.c1 = c1; r.er = er; r.ef = ef;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    localparam logic [DW-1:0] A0 = 35'h100, A1 = 35'h101, B0 = 35'h200, B1 = 35'h201;
    localparam logic [DW-1:0] C0 = 35'h300, C1 = 35'h301, C2 = 35'h302, C3 = 35'h303, C4 = 35'h304;
    localparam logic [DW-1:0] D0 = 35'h400, D1 = 35'h401, XV = 35'h500, YV = 35'h600, ZV = 35'h5A;

    initial begin
        // round robin
        v.push_back(mk(0, 2'b11, A0, B0, 0, BYP,  A0, 0, 0, 0, 2'b11, 0));
        v.push_back(mk(0, 2'b11, A1, B1, 0, 1,    A0, 0, 1, 1, 2'b11, 0));
        v.push_back(mk(0, 2'b00, 0,  0,  1, 1,    A0, 0, 2, 2, 2'b11, 0));
        v.push_back(mk(0, 2'b00, 0,  0,  1, 1,    B0, 1, 1, 2, 2'b11, 0));
        v.push_back(mk(0, 2'b00, 0,  0,  1, 1,    A1, 0, 1, 1, 2'b11, 0));
        v.push_back(mk(0, 2'b00, 0,  0,  1, 1,    B1, 1, 0, 1, 2'b11, 0));
        v.push_back(mk(0, 2'b00, 0,  0,  1, 0,    0,  0, 0, 0, 2'b11, 0));
        // fill lane0, then push+pop while full
        v.push_back(mk(0, 2'b01, C0, 0,  0, BYP,  C0, 0, 0, 0, 2'b11, 0));
        v.push_back(mk(0, 2'b01, C1, 0,  0, 1,    C0, 0, 1, 0, 2'b11, 0));
        v.push_back(mk(0, 2'b01, C2, 0,  0, 1,    C0, 0, 2, 0, 2'b11, 0));
        v.push_back(mk(0, 2'b01, C3, 0,  0, 1,    C0, 0, 3, 0, 2'b11, 0));
        v.push_back(mk(0, 2'b01, C4, 0,  1, 1,    C0, 0, 4, 0, 2'b10, 1));
        v.push_back(mk(0, 2'b00, 0,  0,  0, 1,    C1, 0, 3, 0, 2'b11, 0));
        // lane1 loads under a lane0 lock, then flush beats push and pop
        v.push_back(mk(0, 2'b10, 0,  D0, 0, 1,    C1, 0, 3, 0, 2'b11, 0));
        v.push_back(mk(0, 2'b10, 0,  D1, 0, 1,    C1, 0, 3, 1, 2'b11, 0));
        v.push_back(mk(1, 2'b11, C4, D1, 1, 0,    0,  0, 3, 2, 2'b00, 0));
        v.push_back(mk(0, 2'b00, 0,  0,  1, 0,    0,  0, 0, 0, 2'b11, 0));
        // backpressure lock: lane1 X held while lane0 Y arrives at rr_ptr 0
        v.push_back(mk(0, 2'b10, 0,  XV, 0, BYP,  XV, 1, 0, 0, 2'b11, 0));
        v.push_back(mk(0, 2'b01, YV, 0,  0, 1,    XV, 1, 0, 1, 2'b11, 0));
        v.push_back(mk(0, 2'b00, 0,  0,  0, 1,    XV, 1, 1, 1, 2'b11, 0));
        v.push_back(mk(0, 2'b00, 0,  0,  1, 1,    XV, 1, 1, 1, 2'b11, 0));
        v.push_back(mk(0, 2'b00, 0,  0,  1, 1,    YV, 0, 1, 0, 2'b11, 0));
        v.push_back(mk(0, 2'b00, 0,  0,  1, 0,    0,  0, 0, 0, 2'b11, 0));
        // push-to-out latency into an empty buffer
        v.push_back(mk(0, 2'b10, 0,  ZV, 1, BYP,  ZV, 1, 0, 0, 2'b11, 0));
        v.push_back(mk(0, 2'b00, 0,  0,  1, !BYP, ZV, 1, 0, BYP ? 3'd0 : 3'd1, 2'b11, 0));
        v.push_back(mk(0, 2'b00, 0,  0,  1, 0,    0,  0, 0, 0, 2'b11, 0));

        // reset held with requests pending
        rst = 1'b0; in_valid = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 2'b00);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_lane", out_lane, 0);
        chk("rst_lane_count", lane_count, 0);
        chk("rst_any_full", any_full, 0);
        rst = 1'b1;
        #1;
        chk("rel_in_ready", in_ready, 2'b00);
        chk("rel_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        chk("rel1_in_ready", in_ready, 2'b11);
        chk("rel1_out_valid", out_valid, 0);
        chk("rel1_lane_count", lane_count, 0);
        in_valid = 2'b00;

        for (int i = 0; i < v.size(); i++) begin
            flush     = v[i].fl;
            in_valid  = v[i].iv;
            in_data   = {v[i].d1, v[i].d0};
            out_ready = v[i].ordy;
            #1;
            chk($sformatf("v%0d_out_valid", i), out_valid, v[i].ev);
            chk($sformatf("v%0d_in_ready", i), in_ready, v[i].er);
            chk($sformatf("v%0d_lane_count", i), lane_count, {v[i].c1, v[i].c0});
            chk($sformatf("v%0d_any_full", i), any_full, v[i].ef);
            if (v[i].ev) begin
                chk($sformatf("v%0d_out_data", i), out_data, v[i].ed);
                chk($sformatf("v%0d_out_lane", i), out_lane, v[i].el);
            end
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
